seven_segment_capture: RTL and testbench

- Receive-side monitor for the multiplexed 8-digit seven-segment display bus.
- Samples the active-low anode (`an`) and cathode (`cat`) lines and decodes each lit digit's segment pattern back to a hex nibble.
- Reassembles the full 32-bit displayed value and reports malformed patterns.
- Used for on-board loopback self-test of the display path and as a bench monitor for any block that drives the display.

---
 rtl/seven_seg_pkg.sv | 14 +
 rtl/seg7_to_hex.sv | 22 ++
 rtl/seven_segment_capture.sv | 115 +++++++++++
 tb/tb_seven_segment_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions used by both the display driver and the capture monitor.
// Segment patterns are active-high with bit 0 = segment a through bit 6 = segment g.
package seven_seg_pkg;

   localparam int NUM_DIGITS = 8;

   typedef logic [3:0] hex_digit_t;

   localparam logic [6:0] SEG_PATTERN [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-high segment pattern to its hex nibble.
// o_match is low when the pattern is not one of the sixteen legal glyphs.
module seg7_to_hex
   import seven_seg_pkg::*;
(
   input  logic [6:0] i_seg,
   output hex_digit_t o_nibble,
   output logic       o_match
);

   always_comb begin
      o_nibble = '0;
      o_match  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i_seg == SEG_PATTERN[i]) begin
            o_nibble = hex_digit_t'(i);
            o_match  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive-side monitor for the multiplexed 8-digit seven-segment bus: waits for each
// digit to settle, decodes it, and reassembles the 32-bit displayed value.
module seven_segment_capture
   import seven_seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [6:0]  cat_in,
   input  logic [7:0]  an_in,
   output logic [31:0] val_out,
   output logic        valid_out,
   output logic [7:0]  digit_mask_out,
   output logic        err_out
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

   logic [14:0]     r_sync1, r_sync2;   // {an, cat}
   logic [SW-1:0]   r_settle;
   logic [IW-1:0]   r_idle;
   logic [31:0]     r_asm;
   logic [7:0]      r_mask;
   logic [31:0]     r_val;
   logic            r_valid;
   logic            r_err;

   logic            w_change, w_sample, w_onehot, w_decode, w_write, w_err;
   logic            w_done, w_timeout, w_match;
   logic [7:0]      w_an_act;
   logic [6:0]      w_seg;
   hex_digit_t      w_nibble;
   logic [31:0]     w_asm_next;
   logic [7:0]      w_mask_next;

   // Comparing the two synchronizer stages lets the sample land one edge earlier
   // than watching the second stage alone.
   assign w_change = (r_sync1 != r_sync2);
   assign w_sample = !w_change && (r_settle == SW'(SETTLE_CYCLES - 1));
   assign w_an_act = ~r_sync2[14:7];
   assign w_seg    = ~r_sync2[6:0];
   assign w_onehot = (w_an_act != 8'h00) && ((w_an_act & (w_an_act - 8'd1)) == 8'h00);
   assign w_decode = w_sample && w_onehot;
   assign w_write  = w_decode && w_match;
   assign w_err    = w_sample && (w_onehot ? !w_match : (w_an_act != 8'h00));

   seg7_to_hex u_dec (
      .i_seg    (w_seg),
      .o_nibble (w_nibble),
      .o_match  (w_match)
   );

   always_comb begin
      w_asm_next  = r_asm;
      w_mask_next = r_mask;
      if (w_write) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_an_act[i]) w_asm_next[4*i +: 4] = w_nibble;
         end
         w_mask_next = r_mask | w_an_act;
      end
   end

   assign w_done    = w_write && (w_mask_next == 8'hFF);
   assign w_timeout = !w_decode && (r_idle == IW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_sync1  <= '1;
         r_sync2  <= '1;
         r_settle <= '0;
         r_idle   <= '0;
         r_asm    <= '0;
         r_mask   <= '0;
         r_val    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_sync1 <= {an_in, cat_in};
         r_sync2 <= r_sync1;

         if (w_change)
            r_settle <= '0;
         else if (r_settle != SW'(SETTLE_CYCLES))
            r_settle <= r_settle + 1'b1;

         if (w_decode)
            r_idle <= '0;
         else if (r_idle != IW'(TIMEOUT_CYCLES))
            r_idle <= r_idle + 1'b1;

         r_asm   <= w_asm_next;
         r_valid <= w_done;
         r_err   <= w_err;

         if (w_done) begin
            r_val  <= w_asm_next;
            r_mask <= '0;
         end else if (w_timeout) begin
            r_mask <= '0;
         end else begin
            r_mask <= w_mask_next;
         end
      end
   end

   assign val_out        = r_val;
   assign valid_out      = r_valid;
   assign digit_mask_out = r_mask;
   assign err_out        = r_err;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scenarios plus random bus traffic,
// checked every cycle against a dwell-length model of the display bus.
module tb_seven_segment_capture;

   localparam int S = 4;
   localparam int T = 100;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [6:0]  cat_in = 7'h7F;
   logic [7:0]  an_in = 8'hFF;
   logic [31:0] val_out;
   logic        valid_out;
   logic [7:0]  digit_mask_out;
   logic        err_out;

   int n_checks = 0;
   int n_fail   = 0;
   int valid_seen = 0;
   int err_seen   = 0;

   seven_segment_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .cat_in         (cat_in),
      .an_in          (an_in),
      .val_out        (val_out),
      .valid_out      (valid_out),
      .digit_mask_out (digit_mask_out),
      .err_out        (err_out)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A pin value is taken once, on the edge after it has been seen at S+1
   // consecutive edges.
   logic [14:0] m_prev;
   int          m_run;
   int          m_idle;
   logic [3:0]  m_asm [8];
   logic [7:0]  m_mask;
   logic [31:0] m_val;
   logic        m_valid, m_err;

   task automatic m_reset();
      m_prev = '1; m_run = 1; m_idle = 0; m_mask = 0; m_val = 0;
      m_valid = 0; m_err = 0;
      for (int i = 0; i < 8; i++) m_asm[i] = 0;
   endtask

   task automatic m_step(input logic [14:0] pins);
      logic [7:0] act;
      logic [6:0] seg;
      bit decoded, found;
      int d, n;
      m_valid = 0; m_err = 0; decoded = 0;
      if (m_run == S + 1) begin
         act = ~m_prev[14:7];
         seg = ~m_prev[6:0];
         if ($countones(act) == 1) begin
            decoded = 1;
            found = 0; d = 0; n = 0;
            for (int i = 0; i < 8; i++) if (act[i]) d = i;
            for (int j = 0; j < 16; j++) if (SEG_TAB[j] == seg) begin found = 1; n = j; end
            if (found) begin
               m_asm[d] = 4'(n);
               m_mask = m_mask | act;
               if (m_mask == 8'hFF) begin
                  for (int i = 0; i < 8; i++) m_val[4*i +: 4] = m_asm[i];
                  m_valid = 1;
                  m_mask = 0;
               end
            end else begin
               m_err = 1;
            end
         end else if (act != 0) begin
            m_err = 1;
         end
      end
      if (decoded) m_idle = 0;
      else if (m_idle < T) begin
         m_idle++;
         if (m_idle == T) m_mask = 0;
      end
      if (pins == m_prev) begin
         if (m_run <= S + 1) m_run++;
      end else begin
         m_prev = pins;
         m_run = 1;
      end
   endtask

   // compare process
   initial begin
      m_reset();
      forever begin
         @(posedge clk_in or negedge rst_n_in);
         if (!rst_n_in) begin
            m_reset();
         end else begin
            m_step({an_in, cat_in});
            #1;
            check("val_out", val_out, m_val);
            check("valid_out", 32'(valid_out), 32'(m_valid));
            check("digit_mask_out", 32'(digit_mask_out), 32'(m_mask));
            check("err_out", 32'(err_out), 32'(m_err));
            if (valid_out) valid_seen++;
            if (err_out) err_seen++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; pins are held through `cycles` posedges.
   task automatic drive(input logic [7:0] an, input logic [6:0] cat, input int cycles);
      an_in = an;
      cat_in = cat;
      repeat (cycles) @(negedge clk_in);
   endtask

   task automatic show(input int d, input logic [3:0] n, input int cycles);
      logic [7:0] an;
      an = 8'h01 << d;
      drive(~an, ~SEG_TAB[n], cycles);
   endtask

   task automatic show_frame(input logic [31:0] v);
      for (int i = 0; i < 8; i++) show(i, v[4*i +: 4], 20);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int v0, e0;
      logic [31:0] rv;
      logic [7:0] an;
      logic [6:0] cat;
      int kind, a, b;

      repeat (3) @(negedge clk_in);
      check("reset_val", val_out, 32'h0);
      check("reset_mask", 32'(digit_mask_out), 32'h0);
      rst_n_in = 1'b1;
      repeat (2) @(negedge clk_in);

      // full frame; valid must appear 5 edges into digit 7
      for (int i = 0; i < 7; i++) show(i, 4'(32'hDEADBEEF >> (4*i)), 20);
      show(7, 4'hD, 6);
      check("valid_latency", 32'(valid_out), 32'h1);
      check("frame_val", val_out, 32'hDEADBEEF);
      show(7, 4'hD, 14);
      check("frame_valid_count", 32'(valid_seen), 32'd1);
      check("frame_err_count", 32'(err_seen), 32'd0);

      // illegal glyph on digit 3
      v0 = valid_seen; e0 = err_seen;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) drive(~8'h08, ~7'h7E, 20);
         else show(i, 4'(32'h12345678 >> (4*i)), 20);
      end
      check("bad_glyph_mask", 32'(digit_mask_out), 32'hF7);
      check("bad_glyph_err", 32'(err_seen - e0), 32'd1);
      check("bad_glyph_novalid", 32'(valid_seen - v0), 32'd0);
      show(3, 4'h5, 20);
      check("repair_valid", 32'(valid_seen - v0), 32'd1);
      check("repair_val", val_out, 32'h12345678);

      // two anodes at once, then blanked bus
      e0 = err_seen;
      drive(8'b1111_1100, ~SEG_TAB[1], 20);
      check("multi_err", 32'(err_seen - e0), 32'd1);
      check("multi_mask", 32'(digit_mask_out), 32'h0);
      drive(8'hFF, 7'h7F, 20);
      check("blank_noerr", 32'(err_seen - e0), 32'd1);

      // glitch shorter than the settle window
      show(0, 4'h9, 3);
      show(1, 4'hA, 20);
      check("glitch_mask", 32'(digit_mask_out), 32'h02);

      // timeout discards partial frame
      for (int i = 0; i < 6; i++) show(i, 4'(i), 20);
      check("partial_mask", 32'(digit_mask_out), 32'h3F);
      drive(8'hFF, 7'h7F, T + 10);
      check("timeout_mask", 32'(digit_mask_out), 32'h0);
      check("timeout_val", val_out, 32'h12345678);

      // asynchronous reset mid-frame
      for (int i = 0; i < 4; i++) show(i, 4'(i + 3), 20);
      #2 rst_n_in = 1'b0;
      #1;
      check("async_rst_val", val_out, 32'h0);
      check("async_rst_mask", 32'(digit_mask_out), 32'h0);
      check("async_rst_valid", 32'(valid_out), 32'h0);
      check("async_rst_err", 32'(err_out), 32'h0);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      rv = $urandom;
      show_frame(rv);
      check("post_rst_val", val_out, rv);

      // random traffic
      for (int k = 0; k < 300; k++) begin
         kind = $urandom_range(0, 9);
         an = 8'hFF;
         cat = ~SEG_TAB[$urandom_range(0, 15)];
         if (kind == 0) begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            an[a] = 1'b0; an[b] = 1'b0;
         end else if (kind == 1) begin
            an[$urandom_range(0, 7)] = 1'b0;
            cat = 7'($urandom);
         end else if (kind != 2) begin
            an[$urandom_range(0, 7)] = 1'b0;
         end
         drive(an, cat, $urandom_range(1, 10));
      end
      drive(8'hFF, 7'h7F, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
